// File: rtl/audio_sample_sequencer.sv
// Stereo test-tone playback controller.
// A prescaler produces one sample tick every CLK_DIV cycles. Each tick fetches the left and then
// the right 8-bit sample from a shared single-port synchronous ROM. Both 16-bit DAC words are
// updated together, and a one-cycle strobe marks the update.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   enable            0 forces idle with zeroed outputs
//   loop              1 wraps at the end of the table, 0 stops after the last sample
//   start             one-cycle pulse, (re)starts playback from offset 0
//   mem_rd, mem_addr  ROM read strobe and address (address is 0 when not reading)
//   mem_data          ROM data, valid the cycle after mem_rd
//   left, right       DAC words {4'b0, data, 4'b0}
//   sample_stb        one-cycle pulse when left/right have just been updated
//   busy              high whenever the sequencer is not idle
module audio_sample_sequencer #(
  parameter int unsigned CLK_DIV = 7000,
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned LEN     = 2000,
  parameter int unsigned L_BASE  = 0,
  parameter int unsigned R_BASE  = 2000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              loop,
  input  logic              start,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic [15:0]       left,
  output logic [15:0]       right,
  output logic              sample_stb,
  output logic              busy
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned OffW = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CntW-1:0]   CntMax = CntW'(CLK_DIV - 1);
  localparam logic [OffW-1:0]   OffMax = OffW'(LEN - 1);
  localparam logic [ADDR_W-1:0] LBaseA = ADDR_W'(L_BASE);
  localparam logic [ADDR_W-1:0] RBaseA = ADDR_W'(R_BASE);

  typedef enum logic [2:0] {
    StIdle, StWait, StFetchL, StLatchL, StFetchR, StLatchR, StUpdate
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [OffW-1:0] off_q, off_d;
  logic [7:0]      l_buf_q, l_buf_d, r_buf_q, r_buf_d;
  logic [15:0]     left_q, left_d, right_q, right_d;
  logic            stb_q, stb_d;

  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    l_buf_d = l_buf_q;
    r_buf_d = r_buf_q;
    left_d  = left_q;
    right_d = right_q;
    stb_d   = 1'b0;
    // Prescaler free-runs through the fetch states so the tick period stays exactly CLK_DIV.
    if (state_q == StIdle) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end

    if (!enable) begin
      state_d = StIdle;
      cnt_d   = '0;
      off_d   = '0;
      l_buf_d = '0;
      r_buf_d = '0;
      left_d  = '0;
      right_d = '0;
    end else if (start) begin
      // Restart drops any in-flight fetch; left/right keep their current values.
      state_d = StWait;
      cnt_d   = '0;
      off_d   = '0;
    end else begin
      unique case (state_q)
        StIdle:   state_d = StIdle;
        StWait:   if (cnt_q == CntMax) state_d = StFetchL;
        StFetchL: state_d = StLatchL;
        StLatchL: begin
          l_buf_d = mem_data;
          state_d = StFetchR;
        end
        StFetchR: state_d = StLatchR;
        StLatchR: begin
          r_buf_d = mem_data;
          state_d = StUpdate;
        end
        StUpdate: begin
          left_d  = {4'b0, l_buf_q, 4'b0};
          right_d = {4'b0, r_buf_q, 4'b0};
          stb_d   = 1'b1;
          state_d = StWait;
          if (off_q == OffMax) begin
            off_d = '0;
            if (!loop) begin
              state_d = StIdle;
              cnt_d   = '0;
            end
          end else begin
            off_d = off_q + OffW'(1);
          end
        end
        default:  state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      off_q   <= '0;
      l_buf_q <= '0;
      r_buf_q <= '0;
      left_q  <= '0;
      right_q <= '0;
      stb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      off_q   <= off_d;
      l_buf_q <= l_buf_d;
      r_buf_q <= r_buf_d;
      left_q  <= left_d;
      right_q <= right_d;
      stb_q   <= stb_d;
    end
  end

  // Read strobe and address decode straight from the state register.
  always_comb begin
    mem_rd   = 1'b0;
    mem_addr = '0;
    if (state_q == StFetchL) begin
      mem_rd   = 1'b1;
      mem_addr = LBaseA + ADDR_W'(off_q);
    end else if (state_q == StFetchR) begin
      mem_rd   = 1'b1;
      mem_addr = RBaseA + ADDR_W'(off_q);
    end
  end

  assign left       = left_q;
  assign right      = right_q;
  assign sample_stb = stb_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_audio_sample_sequencer.sv
// Self-checking bench for audio_sample_sequencer with a small ROM model (1-cycle latency).
module tb_audio_sample_sequencer;

  localparam int unsigned CLK_DIV = 16;
  localparam int unsigned ADDR_W  = 4;
  localparam int unsigned LEN     = 4;
  localparam int unsigned L_BASE  = 0;
  localparam int unsigned R_BASE  = 8;
  localparam int FirstStb = CLK_DIV + 6;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic enable = 1'b0;
  logic loop = 1'b0;
  logic start = 1'b0;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data = 8'h00;
  logic [15:0]       left, right;
  logic              sample_stb, busy;

  logic [7:0]        rom [2**ADDR_W];
  logic              rd_s = 1'b0;
  logic [ADDR_W-1:0] addr_s = '0;
  logic [15:0]       m_left = 16'h0;
  logic [15:0]       m_right = 16'h0;
  int checks = 0;
  int errors = 0;

  audio_sample_sequencer #(
    .CLK_DIV(CLK_DIV),
    .ADDR_W (ADDR_W),
    .LEN    (LEN),
    .L_BASE (L_BASE),
    .R_BASE (R_BASE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .loop      (loop),
    .start     (start),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .left      (left),
    .right     (right),
    .sample_stb(sample_stb),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // ROM: data for a read appears one cycle later; garbage otherwise.
  always @(negedge clk) begin
    rd_s   <= mem_rd;
    addr_s <= mem_addr;
  end
  always @(posedge clk) mem_data <= rd_s ? rom[addr_s] : 8'($urandom);

  task automatic step();
    @(negedge clk);
  endtask

  // Cycle j after a start pulse: phase within the sample period (-1 before the first tick).
  function automatic int phase_of(int j);
    return (j >= int'(CLK_DIV)) ? (j - int'(CLK_DIV)) % int'(CLK_DIV) : -1;
  endfunction

  function automatic int tick_of(int j);
    return (j - int'(CLK_DIV)) / int'(CLK_DIV);
  endfunction

  function automatic logic [15:0] smp(int idx);
    return {4'h0, rom[idx], 4'h0};
  endfunction

  task automatic fill_random_rom();
    for (int i = 0; i < 2**ADDR_W; i++) rom[i] = 8'($urandom_range(1, 255));
  endtask

  task automatic test_reset();
    enable = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL reset_rd got %b want 0", mem_rd); end
    checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_addr got %h want 0", mem_addr); end
    checks++; if (sample_stb !== 1'b0) begin errors++; $display("FAIL reset_stb got %b want 0", sample_stb); end
    checks++; if (left !== 16'h0 || right !== 16'h0) begin
      errors++; $display("FAIL reset_lr got %h/%h want 0000/0000", left, right);
    end
    step(); step();
    rst_n = 1'b1;
    for (int j = 0; j < 5; j++) begin
      step();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle got busy=%b want 0", busy); end
    end
  endtask

  task automatic test_loop();
    int p, k;
    for (int i = 0; i < int'(LEN); i++) begin
      rom[L_BASE+i] = 8'h11 + 8'(i);
      rom[R_BASE+i] = 8'hA1 + 8'(i);
    end
    loop = 1'b1; enable = 1'b1; start = 1'b1;
    for (int j = 1; j <= FirstStb + int'(CLK_DIV * LEN); j++) begin
      step(); start = 1'b0;
      p = phase_of(j); k = tick_of(j);
      if (p == 6) begin
        m_left  = smp(L_BASE + k % LEN);
        m_right = smp(R_BASE + k % LEN);
      end
      checks++; if (sample_stb !== (p == 6)) begin
        errors++; $display("FAIL loop_stb j=%0d got %b want %b", j, sample_stb, p == 6);
      end
      checks++; if (left !== m_left || right !== m_right) begin
        errors++; $display("FAIL loop_lr j=%0d got %h/%h want %h/%h", j, left, right, m_left, m_right);
      end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL loop_busy j=%0d got %b want 1", j, busy); end
    end
  endtask

  task automatic test_one_shot();
    int p, k, n_obs;
    bit live;
    n_obs = 0;
    loop = 1'b0; start = 1'b1;
    for (int j = 1; j <= FirstStb + int'(CLK_DIV * (LEN + 2)); j++) begin
      step(); start = 1'b0;
      p = phase_of(j); k = tick_of(j);
      live = (p >= 0) && (k < int'(LEN));
      if (live && p == 6) begin
        m_left  = smp(L_BASE + k);
        m_right = smp(R_BASE + k);
      end
      if (sample_stb === 1'b1) n_obs++;
      checks++; if (sample_stb !== (live && p == 6)) begin
        errors++; $display("FAIL oneshot_stb j=%0d got %b want %b", j, sample_stb, live && p == 6);
      end
      checks++; if (mem_rd !== (live && (p == 1 || p == 3))) begin
        errors++; $display("FAIL oneshot_rd j=%0d got %b want %b", j, mem_rd, live && (p == 1 || p == 3));
      end
      checks++; if (busy !== (j < FirstStb + int'(CLK_DIV * (LEN - 1)))) begin
        errors++; $display("FAIL oneshot_busy j=%0d got %b", j, busy);
      end
      checks++; if (left !== m_left || right !== m_right) begin
        errors++; $display("FAIL oneshot_lr j=%0d got %h/%h want %h/%h", j, left, right, m_left, m_right);
      end
    end
    checks++; if (n_obs != int'(LEN)) begin
      errors++; $display("FAIL oneshot_count got %0d want %0d", n_obs, LEN);
    end
  endtask

  task automatic test_fetch_timing();
    int p, k;
    bit erd;
    logic [ADDR_W-1:0] ea;
    fill_random_rom();
    loop = 1'b1; start = 1'b1;
    for (int j = 1; j <= FirstStb + int'(CLK_DIV * (LEN + 1)); j++) begin
      step(); start = 1'b0;
      p = phase_of(j); k = tick_of(j);
      erd = (p == 1 || p == 3);
      ea = (p == 1) ? ADDR_W'(L_BASE + k % LEN) : (p == 3) ? ADDR_W'(R_BASE + k % LEN) : '0;
      if (p == 6) begin
        m_left  = smp(L_BASE + k % LEN);
        m_right = smp(R_BASE + k % LEN);
      end
      checks++; if (mem_rd !== erd) begin
        errors++; $display("FAIL fetch_rd j=%0d got %b want %b", j, mem_rd, erd);
      end
      checks++; if (mem_addr !== ea) begin
        errors++; $display("FAIL fetch_addr j=%0d got %h want %h", j, mem_addr, ea);
      end
      checks++; if (sample_stb !== (p == 6)) begin
        errors++; $display("FAIL fetch_stb j=%0d got %b want %b", j, sample_stb, p == 6);
      end
      checks++; if (left !== m_left || right !== m_right) begin
        errors++; $display("FAIL fetch_lr j=%0d got %h/%h want %h/%h", j, left, right, m_left, m_right);
      end
    end
  endtask

  task automatic test_restart();
    int p, k, stop;
    fill_random_rom();
    loop = 1'b1; start = 1'b1;
    // Restart lands somewhere in FETCH_L..LATCH_R of the third sample.
    stop = int'(CLK_DIV * 3) + int'($urandom_range(1, 4));
    for (int j = 1; j <= stop; j++) begin
      step(); start = 1'b0;
      p = phase_of(j); k = tick_of(j);
      if (p == 6) begin
        m_left  = smp(L_BASE + k % LEN);
        m_right = smp(R_BASE + k % LEN);
      end
      checks++; if (sample_stb !== (p == 6)) begin
        errors++; $display("FAIL restart_pre_stb j=%0d got %b want %b", j, sample_stb, p == 6);
      end
    end
    start = 1'b1;
    for (int j = 1; j <= FirstStb + int'(CLK_DIV); j++) begin
      step(); start = 1'b0;
      p = phase_of(j); k = tick_of(j);
      if (p == 6) begin
        m_left  = smp(L_BASE + k % LEN);
        m_right = smp(R_BASE + k % LEN);
      end
      checks++; if (sample_stb !== (p == 6)) begin
        errors++; $display("FAIL restart_stb j=%0d got %b want %b", j, sample_stb, p == 6);
      end
      checks++; if (left !== m_left || right !== m_right) begin
        errors++; $display("FAIL restart_lr j=%0d got %h/%h want %h/%h", j, left, right, m_left, m_right);
      end
    end
  endtask

  task automatic test_enable_drop();
    int p, k, d, w;
    fill_random_rom();
    loop = 1'b1; enable = 1'b1; start = 1'b1;
    d = int'(CLK_DIV * 2) + 7 + int'($urandom_range(0, 7));
    for (int j = 1; j <= d; j++) begin
      step(); start = 1'b0;
      p = phase_of(j); k = tick_of(j);
      if (p == 6) begin
        m_left  = smp(L_BASE + k % LEN);
        m_right = smp(R_BASE + k % LEN);
      end
      checks++; if (left !== m_left || right !== m_right) begin
        errors++; $display("FAIL endrop_pre_lr j=%0d got %h/%h want %h/%h", j, left, right, m_left, m_right);
      end
    end
    enable = 1'b0;
    step();
    m_left = 16'h0; m_right = 16'h0;
    checks++; if (left !== 16'h0 || right !== 16'h0) begin
      errors++; $display("FAIL endrop_lr got %h/%h want 0000/0000", left, right);
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL endrop_busy got %b want 0", busy); end
    checks++; if (mem_rd !== 1'b0 || sample_stb !== 1'b0) begin
      errors++; $display("FAIL endrop_rd_stb got %b/%b want 0/0", mem_rd, sample_stb);
    end
    start = 1'b1;
    step(); start = 1'b0;
    for (int j = 0; j < 40; j++) begin
      checks++; if (busy !== 1'b0 || mem_rd !== 1'b0 || sample_stb !== 1'b0) begin
        errors++; $display("FAIL endis_start_idle j=%0d got busy=%b rd=%b stb=%b want 0", j, busy, mem_rd,
                           sample_stb);
      end
      step();
    end
    enable = 1'b1; start = 1'b1;
    w = int'($urandom_range(2, 40));
    for (int j = 1; j <= w; j++) begin
      step(); start = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL endrop_run_busy j=%0d got %b want 1", j, busy); end
    end
    enable = 1'b0; start = 1'b1;
    step(); start = 1'b0;
    checks++; if (busy !== 1'b0 || left !== 16'h0 || right !== 16'h0) begin
      errors++; $display("FAIL endrop_start_same got busy=%b lr=%h/%h want 0", busy, left, right);
    end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL endrop_start_stay got %b want 0", busy); end
    enable = 1'b1;
  endtask

  task automatic test_async_reset();
    int p, k;
    fill_random_rom();
    loop = 1'b1; enable = 1'b1; start = 1'b1;
    for (int j = 1; j <= int'(CLK_DIV * 2) + 1; j++) begin
      step(); start = 1'b0;
      p = phase_of(j); k = tick_of(j);
      if (p == 6) begin
        m_left  = smp(L_BASE + k % LEN);
        m_right = smp(R_BASE + k % LEN);
      end
      checks++; if (left !== m_left || right !== m_right) begin
        errors++; $display("FAIL arst_pre_lr j=%0d got %h/%h want %h/%h", j, left, right, m_left, m_right);
      end
    end
    checks++; if (mem_rd !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL arst_pre_fetch got rd=%b busy=%b want 1/1", mem_rd, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    m_left = 16'h0; m_right = 16'h0;
    checks++; if (mem_rd !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL arst_now got rd=%b busy=%b want 0/0", mem_rd, busy);
    end
    checks++; if (left !== 16'h0 || right !== 16'h0) begin
      errors++; $display("FAIL arst_lr got %h/%h want 0000/0000", left, right);
    end
    step();
    rst_n = 1'b1;
    for (int j = 0; j < 40; j++) begin
      step();
      checks++; if (busy !== 1'b0 || mem_rd !== 1'b0 || sample_stb !== 1'b0 || left !== 16'h0) begin
        errors++; $display("FAIL arst_idle j=%0d got busy=%b rd=%b stb=%b left=%h want 0", j, busy, mem_rd,
                           sample_stb, left);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 2**ADDR_W; i++) rom[i] = 8'h00;
    test_reset();
    test_loop();
    test_one_shot();
    test_fetch_timing();
    test_restart();
    test_enable_drop();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
